// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: loads a parallel pattern and shifts it out LSB first with a valid
// strobe and a done pulse. Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit.
module serial_pattern_tx #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] pattern_i,
   input  logic [CNT_W-1:0] len_i,
   output logic             ready_o,
   output logic             x_o,
   output logic             x_valid_o,
   output logic             done_o,
   output logic [1:0]       ps_o
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StLoad  = 2'b01,
      StShift = 2'b10,
      StDone  = 2'b11
   } state_e;

   localparam logic [CNT_W-1:0] WidthC = CNT_W'(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_eff;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   // Bit and strobe that will be registered onto x_o / x_valid_o at the coming edge.
   logic             bit_nx, valid_nx;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
   logic             par_q, par_d;
   logic             par_sent_q, par_sent_d;
`endif

   assign len_eff = (len_i > WidthC) ? WidthC : len_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         shreg_q    <= '0;
         cnt_q      <= '0;
         x_q        <= 1'b0;
         x_valid_q  <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
         par_q      <= 1'b0;
         par_sent_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         x_q        <= x_d;
         x_valid_q  <= x_valid_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
         par_q      <= par_d;
         par_sent_q <= par_sent_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      bit_nx   = 1'b0;
      valid_nx = 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      par_d      = par_q;
      par_sent_d = par_sent_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start_i && (len_i != '0)) begin
               state_d = StLoad;
               shreg_d = pattern_i;
               cnt_d   = len_eff;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
               par_d      = 1'b0;
               par_sent_d = 1'b0;
`endif
            end
         end
         StLoad: begin
            state_d  = StShift;
            valid_nx = 1'b1;
         end
         StShift: begin
            if (cnt_q != '0) begin
               valid_nx = 1'b1;
            end else begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
               if (!par_sent_q) begin
                  par_sent_d = 1'b1;
                  bit_nx     = par_q;
                  valid_nx   = 1'b1;
               end else begin
                  state_d = StDone;
               end
`else
               state_d = StDone;
`endif
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A data bit is emitted whenever the counter still holds bits to send.
      if (valid_nx && (cnt_q != '0)) begin
         bit_nx  = shreg_q[0];
         shreg_d = shreg_q >> 1;
         cnt_d   = cnt_q - 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
         par_d   = par_q ^ shreg_q[0];
`endif
      end
   end

   always_comb begin
      x_d       = bit_nx & valid_nx;
      x_valid_d = valid_nx;
      ready_d   = (state_d == StIdle);
      done_d    = (state_d == StDone);
   end

   assign ready_o   = ready_q;
   assign x_o       = x_q;
   assign x_valid_o = x_valid_q;
   assign done_o    = done_q;
   assign ps_o      = state_q;

endmodule

// File: doc/serial_pattern_tx.md
Name:
serial_pattern_tx

Overview:
Serial bit-sequence transmitter that drives the single-bit `x` stream consumed by the lab's sequence-detector FSMs.
- Accepts a parallel pattern and a bit count through a start/ready handshake.
- Shifts the pattern out one bit per clock, LSB first, with a valid strobe.
- Pulses `done` when the sequence is complete.
- Replaces hand-timed `x` stimulus on detector benches and boards, so a detector can be driven from a stored pattern.

Parameters:
WIDTH, 16, maximum pattern length in bits.
CNT_W, 5, width of the length field and bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request to transmit; sampled only in IDLE.
pattern  input  WIDTH  bits to send; bit 0 goes first.
len  input  CNT_W  number of bits to send, 1..WIDTH.
ready  output  1  high only in IDLE.
x  output  1  serial data bit, registered.
x_valid  output  1  high while `x` carries a pattern bit.
done  output  1  one-cycle pulse after the last bit.
PS  output  2  present state, for observation.

Behaviour:
- Reset: `rst`=1 immediately forces PS=IDLE, x=0, x_valid=0, done=0, ready=1, and clears the shift register and counter. This applies at any time, including mid-SHIFT; the in-flight pattern is discarded and nothing resumes after reset.
- State encoding: IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, DONE=2'b11. The state register is reported directly on `PS`.
- IDLE:
  - ready=1, x=0, x_valid=0.
  - `start`=1 with len!=0 at an edge: capture `pattern` into the shift register and effective length into the counter; go to LOAD.
  - `start`=1 with len=0: ignored, remain in IDLE.
- Effective length = min(len, WIDTH); len > WIDTH is clamped to WIDTH.
- LOAD: one cycle, ready=0, x=0, x_valid=0. Unconditionally goes to SHIFT.
- SHIFT:
  - Each edge in SHIFT drives x = shreg[0] and x_valid=1, then shifts the register right by one and decrements the counter.
  - After the counter reaches 0, the next edge goes to DONE.
  - x_valid is high for exactly (effective length) consecutive cycles.
- DONE: done=1, x=0, x_valid=0 for one cycle, then IDLE.
- Latency: `start` sampled at edge E0 → first bit valid after E1; last bit after E(n); done after E(n+1); ready after E(n+2).
- Input sampling:
  - `start` while not in IDLE is ignored; it is not queued.
  - `pattern` and `len` are sampled only at the accepting edge; later changes have no effect on the current transfer.
- Output registering: all outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_PATTERN_TX_PARITY_EN.
- Defined:
  - An even-parity bit is appended after the last data bit: x = XOR of the transmitted bits, with x_valid=1.
  - x_valid is therefore high for n+1 cycles, and `done` follows one cycle later.
  - The parity bit covers only the effective-length bits.
- Undefined: no parity cycle; behaviour exactly as in Behaviour.

Test Plan:
- Reset: assert `rst` asynchronously mid-cycle → PS=00, ready=1, x=0, x_valid=0, done=0 before the next edge.
- Basic send: pattern=16'h00B5, len=8, `start` one cycle → x sequence 1,0,1,0,1,1,0,1 with x_valid high 8 cycles; done pulses once; ready returns 10 cycles after the accepting edge.
- Boundaries:
  - len=0 with `start` → stays IDLE, x_valid never asserted.
  - len=1, pattern bit0=1 → a single x=1 valid cycle.
  - len=31 → clamped to 16 valid cycles.
- Ignored inputs: `start` held high throughout a len=4 transfer, with `pattern` changed mid-transfer → original 4 bits sent unchanged; a new transfer begins only on the edge after return to IDLE.
- Abort: `rst` pulsed during the 3rd bit of len=8 → x_valid drops immediately; after release, PS=00 and a new `start` sends its full pattern.
- Parity build: with SERIAL_PATTERN_TX_PARITY_EN, pattern=16'h0007, len=3 → bits 1,1,1 then parity 1; x_valid high 4 cycles.
